// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Op encodings are also imported by the decoder and hazard unit, so they
// must stay in sync with the instruction decode tables.
// Optional feature macro: MDU_MADD_EN (enables MADD/MSUB accumulate ops).
package mdu_pkg;

   // Operation select presented on the Op port
   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5,
      MDU_MADD  = 3'd6,
      MDU_MSUB  = 3'd7
   } mdu_op_e;

   // Control FSM: idle, or counting down a multiply or divide
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   // Default busy periods
   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;

   // Counter must hold the longer of the two busy periods
   function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
      int longest;
      longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return $clog2(longest + 1);
   endfunction

   // True for ops whose multiplier operands are sign-extended
   function automatic logic mdu_mul_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
   endfunction

endpackage

// File: rtl/mdu_div.sv
// mdu_div: combinational 32-bit signed/unsigned divider.
// Produces quotient and remainder with truncation toward zero and the
// remainder carrying the dividend's sign. 0x80000000 / -1 falls out of the
// magnitude arithmetic as quotient 0x80000000, remainder 0. A zero divisor
// raises div_zero and forces both results to zero.
module mdu_div (
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_zero
);

   logic        neg_dvd;
   logic        neg_dvs;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [32:0] part;
   logic [31:0] shq;

   // Strip signs so the core divider only ever sees magnitudes
   always_comb begin
      neg_dvd  = is_signed & dividend[31];
      neg_dvs  = is_signed & divisor[31];
      dvd_mag  = neg_dvd ? (~dividend + 32'd1) : dividend;
      dvs_mag  = neg_dvs ? (~divisor + 32'd1) : divisor;
      div_zero = (divisor == 32'd0);
   end

   // Unrolled restoring division on the magnitudes, one quotient bit per step
   always_comb begin
      part = '0;
      shq  = dvd_mag;
      for (int i = 0; i < 32; i++) begin
         part = {part[31:0], shq[31]};
         shq  = {shq[30:0], 1'b0};
         if (part >= {1'b0, dvs_mag}) begin
            part   = part - {1'b0, dvs_mag};
            shq[0] = 1'b1;
         end
      end
      q_mag = shq;
      r_mag = part[31:0];
   end

   // Re-apply signs; quotient negative on sign mismatch, remainder follows dividend
   always_comb begin
      quotient  = '0;
      remainder = '0;
      if (!div_zero) begin
         quotient  = (neg_dvd ^ neg_dvs) ? (~q_mag + 32'd1) : q_mag;
         remainder = neg_dvd ? (~r_mag + 32'd1) : r_mag;
      end
   end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit of the EX stage, owning the HI/LO registers.
// Multiplies and divides are computed at the Start edge into a pending
// register and committed to {HI,LO} after a fixed busy period, so the
// pipeline sees a constant latency regardless of operands.
// Optional feature macro: MDU_MADD_EN (MADD/MSUB accumulate into {HI,LO}).
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CNT_W = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_op_e    op;
   mdu_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        pend_wr_q, pend_wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;

   logic        acc_mul;
   logic        acc_div;
   logic        acc_mthi;
   logic        acc_mtlo;
   logic        mul_signed;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic [63:0] mul_res;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic        div_zero;

   assign op = mdu_op_e'(Op);

   // Divider sees the live operands; its result is only captured at acceptance
   mdu_div u_div (
      .dividend  (D1),
      .divisor   (D2),
      .is_signed (op == MDU_DIV),
      .quotient  (div_quot),
      .remainder (div_rem),
      .div_zero  (div_zero)
   );

   // Decode Start into an accepted operation; anything while busy is dropped
   always_comb begin
      acc_mul  = 1'b0;
      acc_div  = 1'b0;
      acc_mthi = 1'b0;
      acc_mtlo = 1'b0;
      if (Start && (state_q == ST_IDLE)) begin
         case (op)
            MDU_MULT, MDU_MULTU: acc_mul  = 1'b1;
            MDU_DIV, MDU_DIVU:   acc_div  = 1'b1;
            MDU_MTHI:            acc_mthi = 1'b1;
            MDU_MTLO:            acc_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB:  acc_mul  = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // One 64x64 multiplier; sign- or zero-extension selects signed/unsigned
   always_comb begin
      mul_signed = mdu_mul_is_signed(op);
      mul_a      = {{32{mul_signed & D1[31]}}, D1};
      mul_b      = {{32{mul_signed & D2[31]}}, D2};
      product    = mul_a * mul_b;
   end

   // Select the 64-bit value a multiply-class op will commit
   always_comb begin
      mul_res = product;
`ifdef MDU_MADD_EN
      case (op)
         MDU_MADD: mul_res = {hi_q, lo_q} + product;
         MDU_MSUB: mul_res = {hi_q, lo_q} - product;
         default:  mul_res = product;
      endcase
`endif
   end

   // Next-state logic: leave IDLE on an accepted op, return on the last count
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (acc_mul) begin
               state_d = ST_MUL;
            end else if (acc_div) begin
               state_d = ST_DIV;
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath updates: load, count down, commit, and mthi/mtlo
   always_comb begin
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = (state_d != ST_IDLE);
      if (acc_mul) begin
         cnt_d     = MUL_LOAD;
         pend_d    = mul_res;
         pend_wr_d = 1'b1;
      end else if (acc_div) begin
         cnt_d     = DIV_LOAD;
         pend_d    = {div_rem, div_quot};
         pend_wr_d = !div_zero;
      end else if (state_q != ST_IDLE) begin
         cnt_d = cnt_q - CNT_ONE;
         if ((cnt_q == CNT_ONE) && pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
         end
      end
      if (acc_mthi) begin
         hi_d = D1;
      end
      if (acc_mtlo) begin
         lo_d = D1;
      end
   end

   // State register; reset discards any in-flight result immediately
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu against an arithmetic reference model.
// Honours MDU_MADD_EN the same way the design does.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] D1;
   logic [31:0] D2;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .Op    (Op),
      .D1    (D1),
      .D2    (D2),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: architectural effect of one accepted op and its busy length
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      n  = 0;
      case (op)
         3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; n = MC; end
         3'd1: begin p = ua * ub;      {m_hi, m_lo} = p; n = MC; end
         3'd2: begin
            if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            n = DC;
         end
         3'd3: begin
            if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            n = DC;
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
`ifdef MDU_MADD_EN
         3'd6: begin p = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = p; n = MC; end
         3'd7: begin p = {m_hi, m_lo} - 64'(sa * sb); {m_hi, m_lo} = p; n = MC; end
`endif
         default: n = 0;
      endcase
   endtask

   // Issue one op at the current negedge; inj >= 0 fires a stray DIVU Start at that busy cycle
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
      logic [31:0] h0;
      logic [31:0] l0;
      int          n;
      int          cnt;
      h0 = m_hi;
      l0 = m_lo;
      model(op, a, b, n);
      Start = 1'b1;
      Op    = op;
      D1    = a;
      D2    = b;
      @(negedge Clk);
      Start = 1'b0;
      D1    = $urandom;
      D2    = $urandom;
      if (n > 0) begin
         chk("hi_hold", HI, h0);
         chk("lo_hold", LO, l0);
         cnt = 0;
         while (Busy && cnt < 64) begin
            if (cnt == inj) begin
               Start = 1'b1;
               Op    = 3'd3;
               D1    = 32'd7;
               D2    = 32'd2;
            end else begin
               Start = 1'b0;
            end
            cnt++;
            @(negedge Clk);
         end
         Start = 1'b0;
         chk("busy_cycles", 32'(cnt), 32'(n));
      end else begin
         chk("busy_low", 32'(Busy), 32'd0);
      end
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst   = 1'b0;
      Start = 1'b0;
      Op    = 3'd0;
      D1    = '0;
      D2    = '0;
      repeat (2) @(negedge Clk);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      Rst = 1'b1;
      @(negedge Clk);

      // mthi/mtlo, one-edge latency, no busy
      run_op(3'd4, 32'h1234_5678, 32'd0, -1);
      run_op(3'd5, 32'h9ABC_DEF0, 32'd0, -1);
      chk("mthi_lit", HI, 32'h1234_5678);
      chk("mtlo_lit", LO, 32'h9ABC_DEF0);

      // multiplies, issued back to back with no idle gap
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1);
      chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
      chk("mult_lo_lit", LO, 32'hFFFF_FFFA);
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
      chk("multu_hi_lit", HI, 32'h0000_0002);
      chk("multu_lo_lit", LO, 32'hFFFF_FFFA);

      // divides
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
      chk("div_lo_lit", LO, 32'hFFFF_FFFD);
      chk("div_hi_lit", HI, 32'hFFFF_FFFF);
      run_op(3'd3, 32'd7, 32'd2, -1);
      chk("divu_lo_lit", LO, 32'd3);
      chk("divu_hi_lit", HI, 32'd1);

      // divide by zero keeps HI/LO but still runs the full busy period
      run_op(3'd4, 32'h11, 32'd0, -1);
      run_op(3'd5, 32'h22, 32'd0, -1);
      run_op(3'd2, 32'd99, 32'd0, -1);
      chk("divz_hi_lit", HI, 32'h11);
      chk("divz_lo_lit", LO, 32'h22);

      // signed overflow case
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      chk("ovf_lo_lit", LO, 32'h8000_0000);
      chk("ovf_hi_lit", HI, 32'd0);

      // Start while busy is ignored; no follow-on operation afterwards
      run_op(3'd0, 32'd1000, 32'hFFFF_FFF0, 1);
      @(negedge Clk);
      chk("ignored_busy", 32'(Busy), 32'd0);
      chk("ignored_hi", HI, m_hi);
      chk("ignored_lo", LO, m_lo);

`ifdef MDU_MADD_EN
      run_op(3'd4, 32'd0, 32'd0, -1);
      run_op(3'd5, 32'd5, 32'd0, -1);
      run_op(3'd6, 32'd2, 32'd3, -1);
      chk("madd_hi_lit", HI, 32'd0);
      chk("madd_lo_lit", LO, 32'd11);
`endif

      // randomized mix, including ops 6/7 in either build
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), -1);
      end

      // asynchronous reset in the middle of a divide
      run_op(3'd4, 32'hAAAA_0001, 32'd0, -1);
      run_op(3'd5, 32'h5555_0002, 32'd0, -1);
      Start = 1'b1;
      Op    = 3'd2;
      D1    = 32'd100;
      D2    = 32'd7;
      @(negedge Clk);
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      #2 Rst = 1'b0;
      #1;
      chk("arst_hi", HI, 32'd0);
      chk("arst_lo", LO, 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      @(negedge Clk);
      Rst  = 1'b1;
      m_hi = '0;
      m_lo = '0;
      repeat (DC + 2) @(negedge Clk);
      chk("post_rst_busy", 32'(Busy), 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);

      // unit resumes normally after reset
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
